// File: rtl/prog_updown_counter_if.sv
//------------------------------------------------------------------------------
// Module      : prog_updown_counter_if
// Description : Control/status bundle for prog_updown_counter. The master side
//               drives enable, direction, load and clear; the slave side
//               (the counter) returns count, terminal-count pulse and sticky
//               overflow.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface prog_updown_counter_if #(
   parameter int WIDTH = 16
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clear;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             overflow;

   modport master (
      output en,
      output up_dn,
      output load,
      output load_val,
      output clear,
      input  count,
      input  tc,
      input  overflow
   );

   modport slave (
      input  en,
      input  up_dn,
      input  load,
      input  load_val,
      input  clear,
      output count,
      output tc,
      output overflow
   );
endinterface

`default_nettype wire

// File: rtl/prog_updown_counter.sv
//------------------------------------------------------------------------------
// Module      : prog_updown_counter
// Description : Up/down event/timebase counter with programmable modulus
//               (0..MAX_VAL), wrap or saturate at the limits, an enable
//               prescaler, synchronous clear/load, a one-cycle terminal-count
//               pulse and a sticky overflow flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prog_updown_counter #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter int               SAT_MODE = 0,
   parameter int               PRESCALE = 1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   prog_updown_counter_if.slave  bus
);

   // A prescale of zero is meaningless; treat it as "step every enabled clock".
   localparam int c_ps      = (PRESCALE < 1) ? 1 : PRESCALE;
   localparam int c_psw     = (c_ps > 1) ? $clog2(c_ps) : 1;
   localparam logic [c_psw-1:0] c_ps_last = c_psw'(c_ps - 1);
   localparam bit c_sat     = (SAT_MODE != 0);

   logic [WIDTH-1:0] r_count;
   logic [c_psw-1:0] r_psc;
   logic             r_tc;
   logic             r_overflow;

   logic             w_psc_last;
   logic             w_step;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_boundary;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_count_step;

   // Out-of-range load values are clamped so the count never leaves 0..MAX_VAL.
   assign w_load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

   // A step fires on the enabled edge that completes a prescale period.
   assign w_psc_last = (r_psc == c_ps_last);
   assign w_step     = bus.en & w_psc_last;

   assign w_at_max   = (r_count == MAX_VAL);
   assign w_at_zero  = (r_count == '0);
   assign w_boundary = w_step & (bus.up_dn ? w_at_max : w_at_zero);

   // Next count for a step, including wrap/saturate behaviour at the limits.
   always_comb begin
      w_count_step = r_count;
      if (bus.up_dn) begin
         if (!w_at_max)
            w_count_step = r_count + 1'b1;
         else if (!c_sat)
            w_count_step = '0;
      end else begin
         if (!w_at_zero)
            w_count_step = r_count - 1'b1;
         else if (!c_sat)
            w_count_step = MAX_VAL;
      end
   end

   // Counter state: clear beats load beats step; tc is asserted only on a boundary edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_psc      <= '0;
         r_tc       <= 1'b0;
         r_overflow <= 1'b0;
      end else if (bus.clear) begin
         r_count    <= '0;
         r_psc      <= '0;
         r_tc       <= 1'b0;
         r_overflow <= 1'b0;
      end else if (bus.load) begin
         r_count    <= w_load_clamped;
         r_psc      <= '0;
         r_tc       <= 1'b0;
      end else if (bus.en) begin
         r_psc      <= w_psc_last ? '0 : r_psc + 1'b1;
         r_tc       <= w_boundary;
         if (w_step)
            r_count <= w_count_step;
         if (w_boundary)
            r_overflow <= 1'b1;
      end else begin
         r_tc       <= 1'b0;
      end
   end

   assign bus.count    = r_count;
   assign bus.tc       = r_tc;
   assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_prog_updown_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_prog_updown_counter
// Description : Self-checking bench for prog_updown_counter. Four instances
//               (defaults, modulus-10 wrap, modulus-10 saturate, prescale-4
//               modulus-101) share one stimulus stream and are compared each
//               cycle against a behavioural model, plus directed checks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prog_updown_counter;

   logic        clk;
   logic        reset;
   logic        en;
   logic        up_dn;
   logic        load;
   logic        clear;
   logic [15:0] lv;

   int total = 0;
   int bad   = 0;

   // model state and per-instance parameters
   int m_cnt [4];
   int m_psc [4];
   int m_tc  [4];
   int m_ovf [4];
   int p_max [4] = '{65535, 9, 9, 100};
   int p_sat [4] = '{0, 0, 1, 0};
   int p_ps  [4] = '{1, 1, 1, 4};
   int p_mod [4] = '{65536, 256, 256, 256};

   prog_updown_counter_if #(.WIDTH(16)) ifa ();
   prog_updown_counter_if #(.WIDTH(8))  ifb ();
   prog_updown_counter_if #(.WIDTH(8))  ifc ();
   prog_updown_counter_if #(.WIDTH(8))  ifd ();

   assign ifa.en = en;  assign ifa.up_dn = up_dn;  assign ifa.load = load;
   assign ifa.clear = clear;  assign ifa.load_val = lv;
   assign ifb.en = en;  assign ifb.up_dn = up_dn;  assign ifb.load = load;
   assign ifb.clear = clear;  assign ifb.load_val = lv[7:0];
   assign ifc.en = en;  assign ifc.up_dn = up_dn;  assign ifc.load = load;
   assign ifc.clear = clear;  assign ifc.load_val = lv[7:0];
   assign ifd.en = en;  assign ifd.up_dn = up_dn;  assign ifd.load = load;
   assign ifd.clear = clear;  assign ifd.load_val = lv[7:0];

   prog_updown_counter u_a (.clk(clk), .reset(reset), .bus(ifa));

   prog_updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .SAT_MODE(0), .PRESCALE(1))
      u_b (.clk(clk), .reset(reset), .bus(ifb));

   prog_updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .SAT_MODE(1), .PRESCALE(1))
      u_c (.clk(clk), .reset(reset), .bus(ifc));

   prog_updown_counter #(.WIDTH(8), .MAX_VAL(8'd100), .SAT_MODE(0), .PRESCALE(4))
      u_d (.clk(clk), .reset(reset), .bus(ifd));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_cnt[i] = 0; m_psc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end
   endtask

   // Applies the counting rules to every model instance for one rising edge.
   task automatic model_update();
      int v;
      for (int i = 0; i < 4; i++) begin
         m_tc[i] = 0;
         if (clear) begin
            m_cnt[i] = 0; m_psc[i] = 0; m_ovf[i] = 0;
         end else if (load) begin
            v = int'(lv) % p_mod[i];
            m_cnt[i] = (v > p_max[i]) ? p_max[i] : v;
            m_psc[i] = 0;
         end else if (en) begin
            m_psc[i] = m_psc[i] + 1;
            if (m_psc[i] == p_ps[i]) begin
               m_psc[i] = 0;
               if (up_dn) begin
                  if (m_cnt[i] < p_max[i]) m_cnt[i] = m_cnt[i] + 1;
                  else begin
                     m_tc[i] = 1; m_ovf[i] = 1;
                     if (p_sat[i] == 0) m_cnt[i] = 0;
                  end
               end else begin
                  if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                  else begin
                     m_tc[i] = 1; m_ovf[i] = 1;
                     if (p_sat[i] == 0) m_cnt[i] = p_max[i];
                  end
               end
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] oc, ot, oo;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin oc = 32'(ifa.count); ot = 32'(ifa.tc); oo = 32'(ifa.overflow); end
            1: begin oc = 32'(ifb.count); ot = 32'(ifb.tc); oo = 32'(ifb.overflow); end
            2: begin oc = 32'(ifc.count); ot = 32'(ifc.tc); oo = 32'(ifc.overflow); end
            default: begin oc = 32'(ifd.count); ot = 32'(ifd.tc); oo = 32'(ifd.overflow); end
         endcase
         check($sformatf("%s_u%0d_count", tag, i), oc, m_cnt[i]);
         check($sformatf("%s_u%0d_tc", tag, i), ot, m_tc[i]);
         check($sformatf("%s_u%0d_ovf", tag, i), oo, m_ovf[i]);
      end
   endtask

   // One clock: inputs were set at the preceding falling edge.
   task automatic tick(input string tag);
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; clear = 1'b0; lv = '0;
      model_reset();
      #1 check_all("reset");
      @(negedge clk);
      reset = 1'b1;

      // defaults: ten enabled edges, then an asynchronous reset between edges
      en = 1'b1; up_dn = 1'b1;
      repeat (10) tick("t1");
      check("t1_count10", 32'(ifa.count), 10);
      #1 reset = 1'b0;
      #1;
      check("t1_async_count", 32'(ifa.count), 0);
      check("t1_async_tc", 32'(ifb.tc), 0);
      model_reset();
      @(negedge clk);
      check_all("t1_hold");
      reset = 1'b1;

      // modulus 10 wrap upward
      clear = 1'b1; tick("t2_clr"); clear = 1'b0;
      repeat (9) tick("t2");
      check("t2_b_at9", 32'(ifb.count), 9);
      tick("t2_wrap");
      check("t2_b_wrap_count", 32'(ifb.count), 0);
      check("t2_b_wrap_tc", 32'(ifb.tc), 1);
      check("t2_b_wrap_ovf", 32'(ifb.overflow), 1);
      tick("t2_next");
      check("t2_b_next_count", 32'(ifb.count), 1);
      check("t2_b_next_tc", 32'(ifb.tc), 0);

      // downward from zero: wrap vs saturate
      clear = 1'b1; tick("t3_clr"); clear = 1'b0;
      up_dn = 1'b0;
      tick("t3");
      check("t3_b_count", 32'(ifb.count), 9);
      check("t3_b_tc", 32'(ifb.tc), 1);
      check("t3_c_count", 32'(ifc.count), 0);
      check("t3_c_tc", 32'(ifc.tc), 1);
      check("t3_c_ovf", 32'(ifc.overflow), 1);
      tick("t3b");
      check("t3_c_count2", 32'(ifc.count), 0);
      check("t3_c_tc2", 32'(ifc.tc), 1);

      // prescale 4
      clear = 1'b1; tick("t4_clr"); clear = 1'b0;
      up_dn = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick("t4");
         check($sformatf("t4_d_edge%0d", k), 32'(ifd.count), k / 4);
      end
      clear = 1'b1; tick("t4_clr2"); clear = 1'b0;
      repeat (2) tick("t4_pre");
      en = 1'b0;
      repeat (5) tick("t4_hold");
      check("t4_d_hold", 32'(ifd.count), 0);
      en = 1'b1;
      tick("t4_resume1");
      check("t4_d_resume1", 32'(ifd.count), 0);
      tick("t4_resume2");
      check("t4_d_resume2", 32'(ifd.count), 1);

      // load clamp, overflow retention, clear beats load
      en = 1'b0; load = 1'b1; lv = 16'd250;
      tick("t5_load");
      load = 1'b0;
      check("t5_d_clamp", 32'(ifd.count), 100);
      en = 1'b1; up_dn = 1'b1;
      repeat (4) tick("t5_wrap");
      check("t5_d_wrap_count", 32'(ifd.count), 0);
      check("t5_d_wrap_tc", 32'(ifd.tc), 1);
      en = 1'b0; load = 1'b1; lv = 16'd50;
      tick("t5_load2");
      check("t5_d_load50", 32'(ifd.count), 50);
      check("t5_d_ovf_kept", 32'(ifd.overflow), 1);
      clear = 1'b1;
      tick("t5_clrload");
      clear = 1'b0; load = 1'b0;
      check("t5_d_clr_count", 32'(ifd.count), 0);
      check("t5_d_clr_ovf", 32'(ifd.overflow), 0);

      // load at MAX_VAL with a pending step
      load = 1'b1; lv = 16'd100;
      tick("t6_load");
      load = 1'b0; en = 1'b1;
      repeat (3) tick("t6_pre");
      check("t6_d_pre", 32'(ifd.count), 100);
      load = 1'b1;
      tick("t6_loadpend");
      load = 1'b0;
      check("t6_d_load_count", 32'(ifd.count), 100);
      check("t6_d_load_tc", 32'(ifd.tc), 0);
      repeat (3) tick("t6_restart");
      check("t6_d_restart", 32'(ifd.count), 100);
      tick("t6_step");
      check("t6_d_step_count", 32'(ifd.count), 0);
      check("t6_d_step_tc", 32'(ifd.tc), 1);

      // randomized traffic against the model
      for (int n = 0; n < 500; n++) begin
         en    = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
         load  = ($urandom_range(0, 19) == 0);
         clear = ($urandom_range(0, 39) == 0);
         lv    = 16'($urandom);
         tick("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
